// File: rtl/s2p_collector_if.sv
// Bus between the serial source and the s2p_collector, plus its outputs.
// Handshake: a serial bit moves on every rising clock edge where i_dv=1. There is
// no ready signal, so the collector accepts every valid bit. On the output side,
// o_dv is a one-cycle pulse with no backpressure. o_data stays valid until the
// next o_dv.
interface s2p_collector_if #(
    parameter int WORD_SIZE = 7,
    parameter int CNT_WIDTH = 16
) ();
    logic                 i_data;
    logic                 i_dv;
    logic [WORD_SIZE-1:0] o_data;
    logic                 o_dv;
    logic                 o_err;
    logic [CNT_WIDTH-1:0] o_word_cnt;
    logic                 o_dbg_collect;   // FSM state: 1 = COLLECT, 0 = IDLE

    modport master (
        output i_data, i_dv,
        input  o_data, o_dv, o_err, o_word_cnt, o_dbg_collect
    );

    modport slave (
        input  i_data, i_dv,
        output o_data, o_dv, o_err, o_word_cnt, o_dbg_collect
    );
endinterface

// File: rtl/s2p_collector.sv
// Serial-to-parallel collector. It rebuilds WORD_SIZE-bit words from an LSB-first
// bit burst. A completed word is flagged with a one-cycle o_dv pulse. A burst that
// stops part-way through a word is discarded and flagged with a one-cycle o_err pulse.
module s2p_collector #(
    parameter int WORD_SIZE = 7,
    parameter int CNT_WIDTH = 16
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    s2p_collector_if.slave    bus
);
    localparam int BW = $clog2(WORD_SIZE) + 1;
    localparam logic [BW-1:0] LAST_BIT = BW'(WORD_SIZE - 1);

    typedef enum logic {IDLE = 1'b0, COLLECT = 1'b1} state_t;

    state_t               state_q, state_d;
    logic [BW-1:0]        bcnt_q, bcnt_d;
    logic [WORD_SIZE-1:0] sr_q, sr_d;
    logic [WORD_SIZE-1:0] data_q, data_d;
    logic                 dv_q, dv_d;
    logic                 err_q, err_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [WORD_SIZE-1:0] sr_shift;

    // The new bit enters at the MSB, so the first bit received ends up at bit 0.
    assign sr_shift = {bus.i_data, sr_q[WORD_SIZE-1:1]};

    // Next-state logic: word assembly, completion and truncation detection.
    always_comb begin
        state_d = state_q;
        bcnt_d  = bcnt_q;
        sr_d    = sr_q;
        data_d  = data_q;
        dv_d    = 1'b0;
        err_d   = 1'b0;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (bus.i_dv) begin
                    sr_d    = sr_shift;
                    bcnt_d  = BW'(1);
                    state_d = COLLECT;
                end
            end
            COLLECT: begin
                if (bus.i_dv) begin
                    sr_d = sr_shift;
                    if (bcnt_q == LAST_BIT) begin
                        // The final bit goes straight to the output register. Returning
                        // to IDLE lets a following bit start the next word with no gap.
                        data_d  = sr_shift;
                        dv_d    = 1'b1;
                        cnt_d   = cnt_q + 1'b1;
                        bcnt_d  = '0;
                        state_d = IDLE;
                    end else begin
                        bcnt_d = bcnt_q + 1'b1;
                    end
                end else begin
                    // A gap in the middle of a word discards the partial word.
                    err_d   = 1'b1;
                    bcnt_d  = '0;
                    sr_d    = '0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers, cleared asynchronously by reset.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            bcnt_q  <= '0;
            sr_q    <= '0;
            data_q  <= '0;
            dv_q    <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            bcnt_q  <= bcnt_d;
            sr_q    <= sr_d;
            data_q  <= data_d;
            dv_q    <= dv_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.o_data        = data_q;
    assign bus.o_dv          = dv_q;
    assign bus.o_err         = err_q;
    assign bus.o_word_cnt    = cnt_q;
    assign bus.o_dbg_collect = (state_q == COLLECT);
endmodule

// File: tb/tb_s2p_collector.sv
// Directed and random bench for s2p_collector. One instance uses a 16-bit counter.
// A second instance uses CNT_WIDTH=2 to exercise counter wrap.
module tb_s2p_collector;
    localparam int W = 7;

    logic i_clk;
    logic i_rst_n;
    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;
    int   err_seen = 0;
    int   err_exp  = 0;
    int   model_cnt = 0;

    logic [W-1:0]  exp_q[$];
    logic [15:0]   cnt_q[$];
    int            dv_times[$];

    s2p_collector_if #(.WORD_SIZE(W), .CNT_WIDTH(16)) m_if ();
    s2p_collector_if #(.WORD_SIZE(W), .CNT_WIDTH(2))  w_if ();

    s2p_collector #(.WORD_SIZE(W), .CNT_WIDTH(16)) u_dut (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .bus     (m_if.slave)
    );

    s2p_collector #(.WORD_SIZE(W), .CNT_WIDTH(2)) u_wrap (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .bus     (w_if.slave)
    );

    // clock / reset
    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // driver tasks: inputs change just after the falling edge
    task automatic send_bit(input logic d);
        @(negedge i_clk);
        m_if.i_data = d;
        m_if.i_dv   = 1'b1;
    endtask

    task automatic idle_cycle();
        @(negedge i_clk);
        m_if.i_dv   = 1'b0;
        m_if.i_data = 1'($urandom_range(0, 1));   // ignored while i_dv=0
    endtask

    task automatic send_word(input logic [W-1:0] w);
        for (int i = 0; i < W; i++) begin
            if (i == W - 1) begin
                model_cnt++;
                exp_q.push_back(w);
                cnt_q.push_back(16'(model_cnt));
            end
            send_bit(w[i]);
        end
    endtask

    task automatic send_word_w(input logic [W-1:0] w);
        for (int i = 0; i < W; i++) begin
            @(negedge i_clk);
            w_if.i_data = w[i];
            w_if.i_dv   = 1'b1;
        end
    endtask

    // scoreboard monitor: samples 1 ns after each rising edge
    always begin
        logic [W-1:0] e;
        logic [15:0]  c;
        @(posedge i_clk);
        #1;
        cyc++;
        if (i_rst_n) begin
            chk("dv_err_exclusive", 64'(m_if.o_dv & m_if.o_err), 64'd0);
            if (m_if.o_dv) begin
                dv_times.push_back(cyc);
                if (exp_q.size() == 0) begin
                    chk("unexpected_dv", 64'(m_if.o_data), 64'h1_0000);
                end else begin
                    e = exp_q.pop_front();
                    c = cnt_q.pop_front();
                    chk("word_data", 64'(m_if.o_data), 64'(e));
                    chk("word_cnt", 64'(m_if.o_word_cnt), 64'(c));
                end
            end
            if (m_if.o_err) err_seen++;
        end
    end

    initial begin
        logic [1:0] wrap_exp[5];
        int waited;
        wrap_exp = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

        m_if.i_data = 1'b0;
        m_if.i_dv   = 1'b0;
        w_if.i_data = 1'b0;
        w_if.i_dv   = 1'b0;
        i_rst_n     = 1'b0;
        repeat (3) @(negedge i_clk);
        chk("rst_data", 64'(m_if.o_data), 64'd0);
        chk("rst_dv", 64'(m_if.o_dv), 64'd0);
        chk("rst_err", 64'(m_if.o_err), 64'd0);
        chk("rst_cnt", 64'(m_if.o_word_cnt), 64'd0);
        chk("rst_state", 64'(m_if.o_dbg_collect), 64'd0);
        i_rst_n = 1'b1;
        idle_cycle();

        // single word 0x55, check one-cycle latency and pulse width
        send_word(7'h55);
        @(posedge i_clk); #1;
        chk("t1_dv", 64'(m_if.o_dv), 64'd1);
        chk("t1_data", 64'(m_if.o_data), 64'h55);
        chk("t1_cnt", 64'(m_if.o_word_cnt), 64'd1);
        idle_cycle();
        @(posedge i_clk); #1;
        chk("t1_dv_width", 64'(m_if.o_dv), 64'd0);
        chk("t1_data_hold", 64'(m_if.o_data), 64'h55);

        // back-to-back words
        dv_times.delete();
        send_word(7'h01);
        send_word(7'h40);
        repeat (3) idle_cycle();
        chk("b2b_count", 64'(dv_times.size()), 64'd2);
        if (dv_times.size() == 2)
            chk("b2b_spacing", 64'(dv_times[1] - dv_times[0]), 64'd7);
        chk("b2b_cnt", 64'(m_if.o_word_cnt), 64'd3);

        // truncation: 3 bits then a gap
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        idle_cycle();
        err_exp++;
        @(posedge i_clk); #1;
        chk("trunc_err", 64'(m_if.o_err), 64'd1);
        chk("trunc_data_held", 64'(m_if.o_data), 64'h40);
        chk("trunc_cnt_held", 64'(m_if.o_word_cnt), 64'd3);
        send_word(7'h2A);
        @(posedge i_clk); #1;
        chk("trunc_next_data", 64'(m_if.o_data), 64'h2A);
        chk("trunc_next_cnt", 64'(m_if.o_word_cnt), 64'd4);

        // reset in the middle of a word
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        #2;
        i_rst_n = 1'b0;
        #1;
        chk("midrst_data", 64'(m_if.o_data), 64'd0);
        chk("midrst_cnt", 64'(m_if.o_word_cnt), 64'd0);
        chk("midrst_dv", 64'(m_if.o_dv), 64'd0);
        chk("midrst_err", 64'(m_if.o_err), 64'd0);
        chk("midrst_state", 64'(m_if.o_dbg_collect), 64'd0);
        model_cnt = 0;
        exp_q.delete();
        cnt_q.delete();
        idle_cycle();
        @(negedge i_clk);
        i_rst_n = 1'b1;
        send_word(7'h7F);
        @(posedge i_clk); #1;
        chk("midrst_word", 64'(m_if.o_data), 64'h7F);
        chk("midrst_word_cnt", 64'(m_if.o_word_cnt), 64'd1);
        idle_cycle();

        // counter wrap on the 2-bit instance
        for (int k = 0; k < 5; k++) begin
            send_word_w(7'($urandom_range(0, 127)));
            @(posedge i_clk); #1;
            chk("wrap_dv", 64'(w_if.o_dv), 64'd1);
            chk("wrap_cnt", 64'(w_if.o_word_cnt), 64'(wrap_exp[k]));
        end
        @(negedge i_clk);
        w_if.i_dv = 1'b0;

        // random loopback-style traffic with idle gaps between words
        for (int k = 0; k < 100; k++) begin
            send_word(7'($urandom_range(0, 127)));
            repeat ($urandom_range(0, 2)) idle_cycle();
        end
        idle_cycle();
        waited = 0;
        while (exp_q.size() != 0 && waited < 20) begin
            @(posedge i_clk);
            waited++;
        end
        #2;
        chk("drain_empty", 64'(exp_q.size()), 64'd0);
        chk("err_total", 64'(err_seen), 64'(err_exp));
        chk("final_cnt", 64'(m_if.o_word_cnt), 64'(model_cnt));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
